vga_rect_fill: RTL

VGA_RECT_FILL -- requirements
Module: vga_rect_fill

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_rect_fill_if.sv | 24 ++
 rtl/vga_rect_walker.sv | 83 ++++++++
 rtl/vga_rect_fill.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the rectangle-fill engine: register map, CTRL/STATUS
// bit positions, the FSM state type, the pixel color type and the address helper.
package vga_pkg;

  // Register offsets, decoded from paddr[4:2]
  localparam logic [2:0] REG_ORIGIN = 3'd0;
  localparam logic [2:0] REG_SIZE   = 3'd1;
  localparam logic [2:0] REG_COLOR  = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  // CTRL bits (write-only pulses)
  localparam int CTRL_START    = 0;
  localparam int CTRL_DONE_CLR = 1;
  localparam int CTRL_ABORT    = 2;

  // STATUS bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef logic [23:0] pixel_color_t;
  typedef logic [9:0]  coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } fill_state_e;

  // Framebuffer word address of pixel (x, y): one 32-bit word per pixel,
  // 1024 words per line.
  function automatic logic [31:0] pixel_addr(logic [31:0] base, coord_t x, coord_t y);
    return base | {10'b0, y, x, 2'b00};
  endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// APB bus bundle, used both for the configuration slave port and for the
// framebuffer master port of the rectangle-fill engine.
interface vga_rect_fill_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/vga_rect_walker.sv
// Raster walker for the rectangle fill: holds the working origin/size copy,
// steps cx/cy, and produces the current pixel address plus last/clip flags.
// Build option: VGA_FILL_CLIP_EN enables off-screen clip flags (otherwise 0).
module vga_rect_walker
  import vga_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h2100_0000,
  parameter int          H_RES   = 640,
  parameter int          V_RES   = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic        advance_i,
  input  coord_t      x0_i,
  input  coord_t      y0_i,
  input  coord_t      w_i,
  input  coord_t      h_i,
  output logic [31:0] addr_o,
  output logic        last_o,
  output logic        clip_first_o,
  output logic        clip_next_o
);

  coord_t x0_q, y0_q, w_q, h_q;
  coord_t cx_q, cy_q;
  coord_t cx_d, cy_d;
  coord_t px, py, nx, ny;
  logic   row_end;
  logic   first_oob, next_oob;

  function automatic logic off_screen(coord_t x, coord_t y);
    return (int'(x) >= H_RES) || (int'(y) >= V_RES);
  endfunction

  assign row_end = (cx_q == w_q - 10'd1);
  assign last_o  = row_end && (cy_q == h_q - 10'd1);
  assign cx_d    = row_end ? 10'd0 : cx_q + 10'd1;
  assign cy_d    = row_end ? cy_q + 10'd1 : cy_q;

  // Coordinates wrap mod 1024 through the 10-bit adders.
  assign px = x0_q + cx_q;
  assign py = y0_q + cy_q;
  assign nx = x0_q + cx_d;
  assign ny = y0_q + cy_d;

  assign addr_o    = pixel_addr(FB_BASE, px, py);
  assign first_oob = off_screen(x0_i, y0_i);
  assign next_oob  = off_screen(nx, ny);

`ifdef VGA_FILL_CLIP_EN
  assign clip_first_o = first_oob;
  assign clip_next_o  = next_oob;
`else
  logic unused_oob;
  assign unused_oob   = first_oob ^ next_oob;
  assign clip_first_o = 1'b0;
  assign clip_next_o  = 1'b0;
`endif

  // Snapshot geometry on load, step the raster position on advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x0_q <= '0;
      y0_q <= '0;
      w_q  <= '0;
      h_q  <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else if (load_i) begin
      x0_q <= x0_i;
      y0_q <= y0_i;
      w_q  <= w_i;
      h_q  <= h_i;
      cx_q <= '0;
      cy_q <= '0;
    end else if (advance_i) begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: APB config slave + FSM driving an APB master that
// writes one 24-bit color word per pixel of a rectangle into the framebuffer.
// Build option: VGA_FILL_CLIP_EN skips pixels outside H_RES x V_RES.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h2100_0000,
  parameter int          H_RES   = 640,
  parameter int          V_RES   = 480
) (
  input  logic            clock,
  input  logic            reset,
  vga_rect_fill_if.slave  cfg,
  vga_rect_fill_if.master fb,
  output logic            irq
);

  fill_state_e  state_q;
  coord_t       org_x_q, org_y_q, size_w_q, size_h_q;
  pixel_color_t color_q, color_work_q;
  logic         done_q, psel_q, penable_q, abort_q;

  logic        busy;
  logic        cfg_access, cfg_wr;
  logic [2:0]  reg_sel;
  logic        geom_wr, ctrl_wr;
  logic        start_req, done_clr_req, abort_req, abort_now;
  logic        size_zero;
  logic        walk_load, walk_adv;
  logic [31:0] walk_addr;
  logic        walk_last, clip_first, clip_next;

  assign busy       = (state_q != ST_IDLE);
  assign cfg_access = cfg.psel & cfg.penable;
  assign cfg_wr     = cfg_access & cfg.pwrite;
  assign reg_sel    = cfg.paddr[4:2];
  assign geom_wr    = cfg_wr && (reg_sel == REG_ORIGIN || reg_sel == REG_SIZE ||
                                 reg_sel == REG_COLOR);
  assign ctrl_wr    = cfg_wr && (reg_sel == REG_CTRL);

  assign start_req    = ctrl_wr & cfg.pwdata[CTRL_START];
  assign done_clr_req = ctrl_wr & cfg.pwdata[CTRL_DONE_CLR];
  assign abort_req    = ctrl_wr & cfg.pwdata[CTRL_ABORT];
  assign abort_now    = abort_q | abort_req;
  assign size_zero    = (size_w_q == 10'd0) || (size_h_q == 10'd0);

  assign cfg.pready  = cfg_access;
  assign cfg.pslverr = busy && (geom_wr || start_req);

  // A skipped (clipped) pixel sits in SETUP with psel low and advances each cycle.
  assign walk_load = (state_q == ST_IDLE) && start_req && !size_zero;
  assign walk_adv  = ((state_q == ST_ACCESS) && fb.pready) ||
                     ((state_q == ST_SETUP) && !psel_q);

  assign fb.paddr   = walk_addr;
  assign fb.psel    = psel_q;
  assign fb.penable = penable_q;
  assign fb.pprot   = 3'b000;
  assign fb.pwrite  = 1'b1;
  assign fb.pwdata  = {8'h00, color_work_q};
  assign fb.pstrb   = 4'b0111;
  assign irq        = done_q;

  logic unused_bits;
  assign unused_bits = ^{cfg.pprot, cfg.pstrb, cfg.paddr[31:5], cfg.paddr[1:0],
                         cfg.pwdata[31:26], cfg.pwdata[15:10], fb.prdata, fb.pslverr};

  vga_rect_walker #(
    .FB_BASE (FB_BASE),
    .H_RES   (H_RES),
    .V_RES   (V_RES)
  ) u_walker (
    .clock        (clock),
    .reset        (reset),
    .load_i       (walk_load),
    .advance_i    (walk_adv),
    .x0_i         (org_x_q),
    .y0_i         (org_y_q),
    .w_i          (size_w_q),
    .h_i          (size_h_q),
    .addr_o       (walk_addr),
    .last_o       (walk_last),
    .clip_first_o (clip_first),
    .clip_next_o  (clip_next)
  );

  // Register readback, decoded combinationally from the offset.
  always_comb begin
    cfg.prdata = '0;
    case (reg_sel)
      REG_ORIGIN: cfg.prdata = {6'b0, org_y_q, 6'b0, org_x_q};
      REG_SIZE:   cfg.prdata = {6'b0, size_h_q, 6'b0, size_w_q};
      REG_COLOR:  cfg.prdata = {8'h00, color_q};
      REG_STATUS: begin
        cfg.prdata[STAT_BUSY] = busy;
        cfg.prdata[STAT_DONE] = done_q;
      end
      default:    cfg.prdata = '0;
    endcase
  end

  // Configuration registers; writes while busy are rejected with pslverr.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      org_x_q  <= '0;
      org_y_q  <= '0;
      size_w_q <= '0;
      size_h_q <= '0;
      color_q  <= '0;
    end else if (geom_wr && !busy) begin
      case (reg_sel)
        REG_ORIGIN: begin
          org_x_q <= cfg.pwdata[9:0];
          org_y_q <= cfg.pwdata[25:16];
        end
        REG_SIZE: begin
          size_w_q <= cfg.pwdata[9:0];
          size_h_q <= cfg.pwdata[25:16];
        end
        REG_COLOR: color_q <= cfg.pwdata[23:0];
        default: ;
      endcase
    end
  end

  // Fill FSM with registered bus outputs; completion overrides DONE_CLR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      color_work_q <= '0;
    end else begin
      if (done_clr_req) done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (start_req) begin
            if (size_zero) begin
              done_q <= 1'b1;
            end else begin
              state_q      <= ST_SETUP;
              psel_q       <= !clip_first;
              penable_q    <= 1'b0;
              color_work_q <= color_q;
            end
          end
        end
        ST_SETUP: begin
          if (psel_q) begin
            // A started transfer always runs to completion, even under abort.
            state_q   <= ST_ACCESS;
            penable_q <= 1'b1;
            if (abort_req) abort_q <= 1'b1;
          end else if (abort_now) begin
            state_q <= ST_IDLE;
          end else if (walk_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            psel_q <= !clip_next;
          end
        end
        ST_ACCESS: begin
          if (abort_req) abort_q <= 1'b1;
          if (fb.pready) begin
            penable_q <= 1'b0;
            if (abort_now) begin
              state_q <= ST_IDLE;
              psel_q  <= 1'b0;
            end else if (walk_last) begin
              state_q <= ST_IDLE;
              psel_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SETUP;
              psel_q  <= !clip_next;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
